// File: rtl/snoop_ctrl_mp_pkg.sv
// Shared definitions for the multi-peer snoop responder: coherence flags,
// snoop opcodes, FSM encoding and a small sizing helper.
package snoop_ctrl_mp_pkg;

  localparam logic [1:0] FLAG_INVALID      = 2'd0;
  localparam logic [1:0] FLAG_SHARED_CLEAN = 2'd1;
  localparam logic [1:0] FLAG_OWNED_CLEAN  = 2'd2;
  localparam logic [1:0] FLAG_OWNED_DIRTY  = 2'd3;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int CYCLE_NUM_DATA_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_REQ    = 3'd2,
    ST_XFER   = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  // Index width that stays at least one bit for a single-peer build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_ctrl_mp_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo N.
module rr_arbiter
  import snoop_ctrl_mp_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/snoop_ctrl_mp.sv
// Multi-peer snoop responder: serves one peer snoop at a time, runs a
// priority write-back for dirty hits and rewrites the hit way's flag.
//
// state  | meaning
// IDLE   | waiting for a snoop; processor not stalled
// EVAL   | classify latched hit/flag (error, miss, clean hit, dirty hit)
// REQ    | requesting the bus for the write-back
// XFER   | write-back data on the bus, CYCLE_NUM_DATA cycles
// UPDATE | ack the served peer, optional flag write, advance pointer
module snoop_ctrl_mp
  import snoop_ctrl_mp_pkg::*;
#(
  parameter int NUM_PEERS      = 2,
  parameter int WAYS           = 4,
  parameter int CYCLE_NUM_DATA = CYCLE_NUM_DATA_DEF,
  parameter int CLC_W          = 4
) (
  input  logic                        plusclk,
  input  logic                        rst_n,
  input  logic [NUM_PEERS-1:0]        snp_valid,
  input  logic [NUM_PEERS-1:0]        snp_op,
  input  logic [NUM_PEERS*WAYS-1:0]   snp_way_hit,
  input  logic [NUM_PEERS*WAYS*2-1:0] snp_flag,
  input  logic                        bus_get,
  output logic                        bus_req,
  output logic [CLC_W-1:0]            bus_req_clc,
  output logic                        tran_buf_input_sel,
  output logic                        pwb_active,
  output logic                        halt,
  output logic [WAYS-1:0]             we_flag_vector,
  output logic [WAYS*2-1:0]           new_flag_vector,
  output logic [NUM_PEERS-1:0]        snp_ack,
  output logic                        snp_error
);

  localparam int IW = idx_width(NUM_PEERS);
  localparam int CW = 4;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          peer_q, peer_d;
  logic [NUM_PEERS-1:0]   gnt_q, gnt_d;
  logic                   op_q, op_d;
  logic [WAYS-1:0]        hit_q, hit_d;
  logic [WAYS*2-1:0]      flag_q, flag_d;
  logic                   wr_q, wr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_PEERS-1:0]   gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic [1:0]             hit_flag;
  logic                   hit_multi;
  logic [1:0]             new_flag;

  rr_arbiter #(.N(NUM_PEERS), .IW(IW)) u_arb (
    .req_i (snp_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    hit_flag = FLAG_INVALID;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_q[w]) hit_flag = hit_flag | flag_q[w*2 +: 2];
    end
    hit_multi = !$onehot0(hit_q);
    new_flag  = (op_q == OP_RD) ? FLAG_SHARED_CLEAN : FLAG_INVALID;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    peer_d   = peer_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    hit_d    = hit_q;
    flag_d   = flag_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;

    bus_req            = 1'b0;
    bus_req_clc        = '0;
    tran_buf_input_sel = 1'b0;
    pwb_active         = 1'b0;
    halt               = 1'b1;
    we_flag_vector     = '0;
    new_flag_vector    = '0;
    snp_ack            = '0;
    snp_error          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        halt = 1'b0;
        if (gnt_any) begin
          for (int p = 0; p < NUM_PEERS; p++) begin
            if (gnt[p]) begin
              op_d   = snp_op[p];
              hit_d  = snp_way_hit[p*WAYS +: WAYS];
              flag_d = snp_flag[p*WAYS*2 +: WAYS*2];
            end
          end
          peer_d  = gnt_idx;
          gnt_d   = gnt;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        wr_d    = 1'b0;
        state_d = ST_UPDATE;
        if (hit_multi) begin
          snp_error = 1'b1;
        end else if (hit_q != '0) begin
          case (hit_flag)
            FLAG_INVALID:     snp_error = 1'b1;
            FLAG_OWNED_DIRTY: begin
              wr_d    = 1'b1;
              state_d = ST_REQ;
            end
            default:          wr_d = 1'b1;
          endcase
        end
      end
      ST_REQ: begin
        bus_req            = 1'b1;
        bus_req_clc        = CLC_W'(CYCLE_NUM_DATA);
        tran_buf_input_sel = 1'b1;
        if (bus_get) begin
          cnt_d   = CW'(CYCLE_NUM_DATA - 1);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        pwb_active         = 1'b1;
        tran_buf_input_sel = 1'b1;
        if (cnt_q == '0) state_d = ST_UPDATE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_UPDATE: begin
        snp_ack  = gnt_q;
        rr_ptr_d = (peer_q == IW'(NUM_PEERS - 1)) ? '0 : peer_q + 1'b1;
        if (wr_q) begin
          we_flag_vector = hit_q;
          for (int w = 0; w < WAYS; w++) begin
            new_flag_vector[w*2 +: 2] = hit_q[w] ? new_flag : FLAG_INVALID;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge plusclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      peer_q   <= '0;
      gnt_q    <= '0;
      op_q     <= 1'b0;
      hit_q    <= '0;
      flag_q   <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      peer_q   <= peer_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      hit_q    <= hit_d;
      flag_q   <= flag_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_snoop_ctrl_mp.sv
// Bench for snoop_ctrl_mp: a 2-peer/2-cycle build and a 4-peer/3-cycle build
// share stimulus; the idle one is held in reset so its outputs stay zero.
module tb_snoop_ctrl_mp;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [3:0]  drv_valid, drv_op;
  logic [15:0] drv_hit;
  logic [31:0] drv_flag;
  logic        bus_get;

  logic       a_req, a_tbs, a_pwb, a_halt, a_err;
  logic [3:0] a_clc, a_we;
  logic [7:0] a_nf;
  logic [1:0] a_ack;
  logic       b_req, b_tbs, b_pwb, b_halt, b_err;
  logic [3:0] b_clc, b_we;
  logic [7:0] b_nf;
  logic [3:0] b_ack;

  logic       req_m, tbs_m, pwb_m, halt_m, err_m;
  logic [3:0] clc_m, we_m, ack_m;
  logic [7:0] nf_m;

  int n_cmp = 0, n_mis = 0;
  int rr_ptr, n_peers, cnd;

  always #5 clk = ~clk;

  snoop_ctrl_mp #(.NUM_PEERS(2), .WAYS(4), .CYCLE_NUM_DATA(2), .CLC_W(4)) u_dut_a (
    .plusclk(clk), .rst_n(rst_a_n),
    .snp_valid(drv_valid[1:0]), .snp_op(drv_op[1:0]),
    .snp_way_hit(drv_hit[7:0]), .snp_flag(drv_flag[15:0]),
    .bus_get(bus_get), .bus_req(a_req), .bus_req_clc(a_clc),
    .tran_buf_input_sel(a_tbs), .pwb_active(a_pwb), .halt(a_halt),
    .we_flag_vector(a_we), .new_flag_vector(a_nf),
    .snp_ack(a_ack), .snp_error(a_err));

  snoop_ctrl_mp #(.NUM_PEERS(4), .WAYS(4), .CYCLE_NUM_DATA(3), .CLC_W(4)) u_dut_b (
    .plusclk(clk), .rst_n(rst_b_n),
    .snp_valid(drv_valid), .snp_op(drv_op),
    .snp_way_hit(drv_hit), .snp_flag(drv_flag),
    .bus_get(bus_get), .bus_req(b_req), .bus_req_clc(b_clc),
    .tran_buf_input_sel(b_tbs), .pwb_active(b_pwb), .halt(b_halt),
    .we_flag_vector(b_we), .new_flag_vector(b_nf),
    .snp_ack(b_ack), .snp_error(b_err));

  assign req_m  = a_req | b_req;
  assign tbs_m  = a_tbs | b_tbs;
  assign pwb_m  = a_pwb | b_pwb;
  assign halt_m = a_halt | b_halt;
  assign err_m  = a_err | b_err;
  assign clc_m  = a_clc | b_clc;
  assign we_m   = a_we | b_we;
  assign nf_m   = a_nf | b_nf;
  assign ack_m  = b_ack | {2'b00, a_ack};

  typedef struct {
    int peer; int op; logic [3:0] hit; logic [7:0] flags; int w;
    int lat; int err; int we; int nf; int pwb;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transaction starting in an IDLE cycle; returns observations and
  // leaves the bench at the following IDLE cycle.
  task automatic run_txn(input int w, output int o_ack, output int o_lat, output int o_err,
                         output int o_we, output int o_nf, output int o_pwb, output int o_bad);
    int req_seen;
    req_seen = 0; o_ack = 0; o_lat = -1; o_err = 0; o_we = 0; o_nf = 0; o_pwb = 0; o_bad = 0;
    bus_get = 1'b0;
    for (int c = 1; c <= 200 && o_lat < 0; c++) begin
      @(posedge clk); #1;
      if (req_m) begin
        req_seen++;
        if (int'(clc_m) != cnd) o_bad++;
      end else if (clc_m != 4'd0) o_bad++;
      if (tbs_m !== (req_m | pwb_m)) o_bad++;
      if (!halt_m) o_bad++;
      if (pwb_m) o_pwb++;
      if (err_m) o_err++;
      bus_get = req_m && (req_seen > w);
      if (ack_m != 4'd0) begin
        o_lat = c; o_ack = int'(ack_m); o_we = int'(we_m); o_nf = int'(nf_m);
        drv_valid = drv_valid & ~ack_m;
      end else if (we_m != 4'd0 || nf_m != 8'd0) o_bad++;
    end
    bus_get = 1'b0;
    if (o_lat < 0) begin
      n_cmp++; n_mis++;
      $display("FAIL timeout: no snp_ack within 200 cycles");
      drv_valid = 4'd0;
    end
    @(posedge clk); #1;
    if (halt_m) o_bad++;
  endtask

  // Reference outcome for one peer, from the flag rules and latency formulas.
  task automatic predict(input int p, input int w, output int lat, output int err,
                         output int we, output int nf, output int pwb);
    logic [3:0] hit;
    logic [7:0] fl;
    int cnt, way, f;
    hit = drv_hit[p*4 +: 4];
    fl  = drv_flag[p*8 +: 8];
    cnt = $countones(hit);
    way = 0;
    for (int k = 0; k < 4; k++) if (hit[k]) way = k;
    f = int'(fl[way*2 +: 2]);
    lat = 2; err = 0; we = 0; nf = 0; pwb = 0;
    if (cnt > 1 || (cnt == 1 && f == 0)) err = 1;
    else if (cnt == 1) begin
      we = int'(hit);
      nf = (drv_op[p] ? 0 : 1) << (2 * way);
      if (f == 3) begin
        pwb = cnd;
        lat = 2 + w + cnd + 1;
      end
    end
  endtask

  task automatic serve_check(input int w);
    int p, e_lat, e_err, e_we, e_nf, e_pwb;
    int o_ack, o_lat, o_err, o_we, o_nf, o_pwb, o_bad;
    p = -1;
    for (int k = 0; k < n_peers; k++) begin
      int q;
      q = (rr_ptr + k) % n_peers;
      if (p < 0 && drv_valid[q]) p = q;
    end
    predict(p, w, e_lat, e_err, e_we, e_nf, e_pwb);
    run_txn(w, o_ack, o_lat, o_err, o_we, o_nf, o_pwb, o_bad);
    check("served_peer", o_ack, 1 << p);
    check("ack_latency", o_lat, e_lat);
    check("snp_error", o_err, e_err);
    check("we_flag", o_we, e_we);
    check("new_flag", o_nf, e_nf);
    check("pwb_cycles", o_pwb, e_pwb);
    check("protocol", o_bad, 0);
    rr_ptr = (p + 1) % n_peers;
  endtask

  task automatic randomize_peers();
    int r;
    for (int p = 0; p < 4; p++) begin
      drv_op[p] = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      drv_hit[p*4 +: 4] = 4'd0;
      else if (r == 1) drv_hit[p*4 +: 4] = 4'($urandom);
      else             drv_hit[p*4 +: 4] = 4'(1 << $urandom_range(0, 3));
      drv_flag[p*8 +: 8] = 8'($urandom);
    end
  endtask

  task automatic random_phase(input int iters);
    int g;
    for (int it = 0; it < iters; it++) begin
      randomize_peers();
      drv_valid = 4'($urandom_range(1, (1 << n_peers) - 1));
      g = 0;
      while (drv_valid != 4'd0 && g < 10) begin
        serve_check($urandom_range(0, 3));
        g++;
      end
    end
  endtask

  initial begin
    int o_ack, o_lat, o_err, o_we, o_nf, o_pwb, o_bad;
    int seen;
    tbl[0] = '{0, 0, 4'b0001, 8'h02, 0, 2, 0, 4'b0001, 8'h01, 0};
    tbl[1] = '{1, 1, 4'b0100, 8'h30, 1, 6, 0, 4'b0100, 8'h00, 2};
    tbl[2] = '{0, 0, 4'b0011, 8'h05, 0, 2, 1, 0, 8'h00, 0};
    tbl[3] = '{1, 0, 4'b0000, 8'hFF, 0, 2, 0, 0, 8'h00, 0};
    tbl[4] = '{0, 0, 4'b1000, 8'h80, 0, 2, 0, 4'b1000, 8'h40, 0};
    tbl[5] = '{1, 0, 4'b0010, 8'hF3, 0, 2, 1, 0, 8'h00, 0};
    tbl[6] = '{0, 0, 4'b0100, 8'h30, 0, 5, 0, 4'b0100, 8'h10, 2};
    tbl[7] = '{1, 1, 4'b0001, 8'h01, 0, 2, 0, 4'b0001, 8'h00, 0};
    tbl[8] = '{0, 1, 4'b0010, 8'h0C, 3, 8, 0, 4'b0010, 8'h00, 2};

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    drv_valid = '0; drv_op = '0; drv_hit = '0; drv_flag = '0; bus_get = 1'b0;
    n_peers = 2; cnd = 2; rr_ptr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {req_m, clc_m, tbs_m, pwb_m, halt_m, we_m, nf_m, ack_m, err_m}, 0);
    rst_a_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drv_valid = 4'(1 << tbl[i].peer);
      drv_op[tbl[i].peer] = 1'(tbl[i].op);
      drv_hit[tbl[i].peer*4 +: 4] = tbl[i].hit;
      drv_flag[tbl[i].peer*8 +: 8] = tbl[i].flags;
      run_txn(tbl[i].w, o_ack, o_lat, o_err, o_we, o_nf, o_pwb, o_bad);
      check($sformatf("tbl%0d_ack", i), o_ack, 1 << tbl[i].peer);
      check($sformatf("tbl%0d_lat", i), o_lat, tbl[i].lat);
      check($sformatf("tbl%0d_err", i), o_err, tbl[i].err);
      check($sformatf("tbl%0d_we", i), o_we, tbl[i].we);
      check($sformatf("tbl%0d_nf", i), o_nf, tbl[i].nf);
      check($sformatf("tbl%0d_pwb", i), o_pwb, tbl[i].pwb);
      check($sformatf("tbl%0d_proto", i), o_bad, 0);
      rr_ptr = (tbl[i].peer + 1) % n_peers;
    end

    // Simultaneous pair, then a pair issued after only peer 0 was served.
    randomize_peers();
    drv_valid = 4'b0011;
    serve_check(0);
    serve_check(1);
    drv_valid = 4'b0001;
    serve_check(0);
    drv_valid = 4'b0011;
    serve_check(2);
    check("pair_order_second", drv_valid, 4'b0001);
    serve_check(0);

    // Reset while the write-back is on the bus.
    drv_valid = 4'b0001; drv_op[0] = 1'b0;
    drv_hit[3:0] = 4'b0010; drv_flag[7:0] = 8'h0C;
    bus_get = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (pwb_m) seen = 1;
    end
    check("reach_xfer", seen, 1);
    rst_a_n = 1'b0;
    #1;
    check("rst_mid_xfer", {req_m, pwb_m, halt_m, tbs_m, ack_m, we_m, err_m}, 0);
    bus_get = 1'b0;
    @(posedge clk); #1;
    check("rst_no_ack", {ack_m, we_m}, 0);
    rst_a_n = 1'b1;
    rr_ptr = 0;
    serve_check(1);

    random_phase(30);

    // Wider build: 4 peers, 3-cycle write-back.
    rst_a_n = 1'b0;
    drv_valid = '0;
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    n_peers = 4; cnd = 3; rr_ptr = 0;
    drv_hit = '0; drv_op = '0;
    drv_valid = 4'b1000;
    serve_check(0);
    check("b_ptr_wrapped", rr_ptr, 0);
    drv_valid = 4'b1001;
    serve_check(0);
    serve_check(0);
    drv_hit[11:8] = 4'b0010; drv_flag[23:16] = 8'h0C;
    drv_valid = 4'b0100;
    run_txn(2, o_ack, o_lat, o_err, o_we, o_nf, o_pwb, o_bad);
    check("b_dirty_ack", o_ack, 4'b0100);
    check("b_dirty_pwb", o_pwb, 3);
    check("b_dirty_lat", o_lat, 8);
    check("b_dirty_nf", o_nf, 8'h04);
    check("b_dirty_proto", o_bad, 0);
    rr_ptr = 3;
    random_phase(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/snoop_ctrl_mp.md
Name: snoop_ctrl_mp

Overview:
- Parametrised multi-peer snoop responder for the L1 cache; next generation of the fixed two-port snoop logic in the L1 control unit.
- Accepts snoop requests from NUM_PEERS peer caches and picks one per transaction, round-robin.
- Resolves the hit way and its coherence flag; runs a priority write-back (PWB) over the bus for OWNED_DIRTY hits, then rewrites the flag.
- Sits between the bus snoop broadcast and the cache table's flag write port; stalls the local processor while busy.

Parameters:
- NUM_PEERS, 2, number of snooping peer caches (1..8).
- WAYS, 4, ways per set; one 2-bit flag per way.
- CYCLE_NUM_DATA, 2, bus cycles needed to transmit one write-back block (1..15).
- CLC_W, 4, width of bus_req_clc.

Ports:
- plusclk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- snp_valid  in  NUM_PEERS  per-peer request; held high until matching snp_ack.
- snp_op  in  NUM_PEERS  per-peer op: 0 = RD, 1 = WR.
- snp_way_hit  in  NUM_PEERS*WAYS  per-peer way-hit vector, peer p at [p*WAYS +: WAYS].
- snp_flag  in  NUM_PEERS*WAYS*2  local set flags per peer, way w at [(p*WAYS+w)*2 +: 2].
- bus_get  in  1  arbiter grant.
- bus_req  out  1  bus request for PWB.
- bus_req_clc  out  CLC_W  cycles requested; equals CYCLE_NUM_DATA while bus_req = 1, else 0.
- tran_buf_input_sel  out  1  1 = transfer buffer sources local dirty block.
- pwb_active  out  1  high during data transfer.
- halt  out  1  processor stall.
- we_flag_vector  out  WAYS  one-hot flag write enable.
- new_flag_vector  out  WAYS*2  new flags; only the enabled way is meaningful, all other ways 0.
- snp_ack  out  NUM_PEERS  one-cycle completion pulse to the served peer.
- snp_error  out  1  one-cycle protocol error pulse.

Behaviour:
- Flag encoding: INVALID = 0, SHARED_CLEAN = 1, OWNED_CLEAN = 2, OWNED_DIRTY = 3.
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, round-robin pointer 0. Reset asserted mid-transfer drops bus_req and pwb_active immediately; no flag write, no ack.
- FSM states: IDLE, EVAL, REQ, XFER, UPDATE.
- IDLE:
  - If any snp_valid is high: select the first requesting peer at or after rr_ptr (wrapping modulo NUM_PEERS).
  - Latch that peer's op, way_hit and flags; go to EVAL.
  - halt = 0 only in IDLE.
- EVAL: decide on the latched way_hit and flag.
  - way_hit has more than one bit set, or the single hit way's flag is INVALID: assert snp_error, go to UPDATE with no write.
  - way_hit = 0 (miss): go to UPDATE with no write.
  - Hit flag OWNED_DIRTY: go to REQ.
  - Any other hit: go to UPDATE with a write.
- REQ:
  - bus_req = 1, bus_req_clc = CYCLE_NUM_DATA, tran_buf_input_sel = 1.
  - On bus_get = 1: load the counter with CYCLE_NUM_DATA-1, go to XFER.
- XFER:
  - pwb_active = 1, tran_buf_input_sel = 1, bus_req = 0.
  - Decrement the counter each cycle; at 0 go to UPDATE.
  - Exactly CYCLE_NUM_DATA XFER cycles.
- UPDATE (one cycle):
  - Pulse snp_ack for the served peer; advance rr_ptr to served+1, wrapping.
  - Write only when required. New flag:
    - RD on SHARED_CLEAN -> SHARED_CLEAN.
    - RD on OWNED_CLEAN -> SHARED_CLEAN.
    - RD on OWNED_DIRTY -> SHARED_CLEAN (after PWB).
    - WR on any valid flag -> INVALID.
  - Return to IDLE.
- Latencies:
  - Clean hit or miss: ack 2 cycles after the valid sample.
  - Dirty hit: ack at 2 + grant wait + CYCLE_NUM_DATA + 1 cycles.
- Simultaneous requests: one transaction at a time. Losers keep valid high and are served in round-robin order; no starvation.
- The inputs of a served peer are not re-sampled after IDLE.

Decomposition:
- Shared package / define file holds:
  - Flag localparams (INVALID..OWNED_DIRTY).
  - RD/WR opcodes.
  - FSM state encodings.
  - Default CYCLE_NUM_DATA.
- One natural sub-module, rr_arbiter: NUM_PEERS request vector plus pointer in, one-hot grant plus index out. Purely combinational.

Test Plan:
- Peer 0, RD, way_hit 0001, way0 flag OWNED_CLEAN -> no bus_req; we_flag_vector = 0001, new_flag way0 = 01; snp_ack = 01 two cycles after valid.
- Peer 1, WR, way_hit 0100, way2 flag OWNED_DIRTY, bus_get one cycle after req:
  - bus_req and bus_req_clc = 2 until grant.
  - pwb_active high for 2 cycles.
  - we_flag_vector = 0100, new flag 00, snp_ack = 10.
- Both peers valid in the same cycle, rr_ptr = 0 -> peer 0 acked first, peer 1 next; a repeat pair is served peer 1 first.
- way_hit 0011 -> snp_error pulse, snp_ack pulse, we_flag_vector stays 0000; way_hit 0000 -> ack only, no error.
- rst_n low during XFER -> bus_req, pwb_active, halt are 0 the same cycle; after release the FSM is in IDLE and the pending peer is re-served from scratch.
- NUM_PEERS = 4, CYCLE_NUM_DATA = 3 build -> dirty-hit pwb_active lasts 3 cycles; round-robin wraps 3 -> 0.
